// File: rtl/intc_pkg.sv
// intc_pkg: shared definitions for the interrupt controller slice.
// FSM state encodings, register byte offsets and small sizing helpers.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } intcState;

    localparam int OFF_ICTL  = 0;
    localparam int OFF_IMASK = 4;
    localparam int OFF_IPEND = 8;
    localparam int OFF_ISRC  = 12;

    // INSVC sits in the top bit of ISRC, whatever the bus width
    function automatic int insvcBit(input int bits);
        return bits - 1;
    endfunction

    // ID width is clog2 of the source count, never narrower than one bit
    function automatic int idWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: combinational lowest-index-first priority encoder.
// Produces the index of the lowest set request bit and an any-set flag.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int IDW  = idWidth(NSRC)
) (
    input  logic [NSRC-1:0] req,
    output logic [IDW-1:0]  id,
    output logic            any
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        id  = '0;
        any = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id  = IDW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: memory-mapped interrupt controller on the shared ABUS/DBUS.
// Latches pending sources, masks them, and sequences one prioritized
// request through IACK and a software EOI write to ISRC.
// Optional feature macro INTC_EDGE_EN: when defined, sources are
// edge-detected and IPEND bits are sticky (W1C / EOI clear); when
// undefined, IPEND simply follows SRC every cycle (level mode).
module intr_ctrl
    import intc_pkg::*;
#(
    parameter int              BITS = 32,
    parameter logic [BITS-1:0] BASE = 32'hF0000100,
    parameter int              NSRC = 4
) (
    input  logic            CLK,
    input  logic            INIT_N,
    input  logic [BITS-1:0] ABUS,
    inout  wire  [BITS-1:0] DBUS,
    input  logic            WE,
    input  logic [NSRC-1:0] SRC,
    input  logic            IACK,
    output logic            IRQ
);

    localparam int IDW   = idWidth(NSRC);
    localparam int INSVC = insvcBit(BITS);

    localparam logic [BITS-1:0] ADDR_ICTL  = BASE + BITS'(OFF_ICTL);
    localparam logic [BITS-1:0] ADDR_IMASK = BASE + BITS'(OFF_IMASK);
    localparam logic [BITS-1:0] ADDR_IPEND = BASE + BITS'(OFF_IPEND);
    localparam logic [BITS-1:0] ADDR_ISRC  = BASE + BITS'(OFF_ISRC);

    logic            gie;
    logic [NSRC-1:0] imask;
    logic [NSRC-1:0] ipend;
    logic [NSRC-1:0] cand;
    logic [IDW-1:0]  id, idNext, winId;
    logic            winAny;
    intcState        state, stateNext;

    logic selCtl, selMask, selPend, selSrc;
    logic wrCtl, wrMask, wrSrc;
    logic rdEn;
    logic [BITS-1:0] rdData;

    // Upper data bits are never stored; keep them visibly consumed
    wire unusedDbus = &{1'b0, DBUS[BITS-1:NSRC]};

    assign selCtl  = (ABUS == ADDR_ICTL);
    assign selMask = (ABUS == ADDR_IMASK);
    assign selPend = (ABUS == ADDR_IPEND);
    assign selSrc  = (ABUS == ADDR_ISRC);

    assign wrCtl  = WE & selCtl;
    assign wrMask = WE & selMask;
    assign wrSrc  = WE & selSrc;

    assign cand = ipend & imask;

    intc_prio_enc #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_prio (
        .req (cand),
        .id  (winId),
        .any (winAny)
    );

    // Control registers: global enable and per-source mask
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            gie   <= 1'b0;
            imask <= '0;
        end else begin
            if (wrCtl)  gie   <= DBUS[0];
            if (wrMask) imask <= DBUS[NSRC-1:0];
        end
    end

`ifdef INTC_EDGE_EN
    logic [NSRC-1:0] srcSample, srcPrev;
    logic [NSRC-1:0] setVec, clrVec, eoiVec;
    logic            wrPend;

    assign wrPend = WE & selPend;
    assign setVec = srcSample & ~srcPrev;
    assign eoiVec = (state == SERV && wrSrc) ? (NSRC'(1) << id) : '0;
    assign clrVec = (wrPend ? DBUS[NSRC-1:0] : '0) | eoiVec;

    // Two-stage source sampling so a rise is detected one edge after it is sampled
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            srcSample <= '0;
            srcPrev   <= '0;
        end else begin
            srcSample <= SRC;
            srcPrev   <= srcSample;
        end
    end

    // Sticky pending bits; a new edge beats a simultaneous W1C or EOI clear
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) ipend <= '0;
        else         ipend <= (ipend & ~clrVec) | setVec;
    end
`else
    // Level mode: pending simply mirrors the sources, clears have no effect
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) ipend <= '0;
        else         ipend <= SRC;
    end
`endif

    // FSM state and committed ID registers
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            state <= IDLE;
            id    <= '0;
        end else begin
            state <= stateNext;
            id    <= idNext;
        end
    end

    // Next-state logic: commit a winner, wait for IACK, then wait for EOI
    always_comb begin
        stateNext = state;
        idNext    = id;
        IRQ       = 1'b0;
        case (state)
            IDLE: begin
                if (gie && winAny) begin
                    idNext    = winId;
                    stateNext = REQ;
                end
            end
            REQ: begin
                IRQ = 1'b1;
                if (IACK) stateNext = SERV;
            end
            SERV: begin
                if (wrSrc) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Combinational read mux over the four registers
    always_comb begin
        rdData = '0;
        if (selCtl) begin
            rdData[0] = gie;
        end else if (selMask) begin
            rdData[NSRC-1:0] = imask;
        end else if (selPend) begin
            rdData[NSRC-1:0] = ipend;
        end else if (selSrc) begin
            rdData[INSVC]   = (state == SERV);
            rdData[IDW-1:0] = id;
        end
    end

    assign rdEn = !WE && (selCtl || selMask || selPend || selSrc);
    assign DBUS = rdEn ? rdData : 'z;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed self-checking bench for intr_ctrl.
// Covers reset, priority, masking, late clears and the EOI sequence in
// whichever mode (INTC_EDGE_EN or level) the design is built in.
module tb_intr_ctrl;

    localparam logic [31:0] BASE       = 32'hF0000100;
    localparam logic [31:0] ADDR_ICTL  = BASE;
    localparam logic [31:0] ADDR_IMASK = BASE + 32'd4;
    localparam logic [31:0] ADDR_IPEND = BASE + 32'd8;
    localparam logic [31:0] ADDR_ISRC  = BASE + 32'd12;
    localparam logic [31:0] ADDR_NONE  = 32'h0000_0000;

    logic        clk    = 1'b0;
    logic        initN  = 1'b0;
    logic [31:0] abus   = ADDR_NONE;
    logic        we     = 1'b0;
    logic [3:0]  src    = 4'b0;
    logic        iack   = 1'b0;
    logic        irq;
    logic        tbDrive = 1'b0;
    logic [31:0] tbData  = 32'h0;
    wire  [31:0] dbus;

    int vecCount = 0;
    int errCount = 0;

    assign dbus = tbDrive ? tbData : 'z;

    always #5 clk = ~clk;

    intr_ctrl #(
        .BITS (32),
        .BASE (BASE),
        .NSRC (4)
    ) dut (
        .CLK    (clk),
        .INIT_N (initN),
        .ABUS   (abus),
        .DBUS   (dbus),
        .WE     (we),
        .SRC    (src),
        .IACK   (iack),
        .IRQ    (irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        abus    = addr;
        tbData  = data;
        tbDrive = 1'b1;
        we      = 1'b1;
        @(negedge clk);
        we      = 1'b0;
        tbDrive = 1'b0;
        abus    = ADDR_NONE;
    endtask

    task automatic checkReg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        abus    = addr;
        we      = 1'b0;
        tbDrive = 1'b0;
        #1;
        d = dbus;
        abus = ADDR_NONE;
        checkOutput(tag, d, exp);
    endtask

    task automatic checkIrq(input string tag, input logic exp);
        checkOutput(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    task automatic pulseIack();
        iack = 1'b1;
        tick();
        iack = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] v);
        src = v;
        tick();
        src = 4'b0;
    endtask

    task automatic waitIrq(input string tag, input int budget);
        for (int i = 0; i < budget && irq !== 1'b1; i++) tick();
        checkIrq(tag, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick();
        tick();
        initN = 1'b1;
        tick();

        checkIrq("reset_irq", 1'b0);
        checkReg("reset_ictl",  ADDR_ICTL,  32'h0);
        checkReg("reset_imask", ADDR_IMASK, 32'h0);
        checkReg("reset_ipend", ADDR_IPEND, 32'h0);
        checkReg("reset_isrc",  ADDR_ISRC,  32'h0);

`ifdef INTC_EDGE_EN
        $display("[TB] edge mode");
        busWrite(ADDR_ICTL, 32'h1);
        busWrite(ADDR_IMASK, 32'h1);
        checkReg("gie_rd", ADDR_ICTL, 32'h1);

        applyStimulus(4'b0001);
        checkIrq("single_edge1", 1'b0);
        tick();
        checkIrq("single_edge2", 1'b0);
        tick();
        checkIrq("single_edge3", 1'b1);
        checkReg("single_isrc_req", ADDR_ISRC, 32'h0);
        pulseIack();
        checkIrq("single_iack_drop", 1'b0);
        checkReg("single_isrc_serv", ADDR_ISRC, 32'h8000_0000);
        busWrite(ADDR_ISRC, 32'h0);
        checkReg("single_ipend_eoi", ADDR_IPEND, 32'h0);
        tick();
        tick();
        checkIrq("single_after_eoi", 1'b0);

        busWrite(ADDR_IMASK, 32'hF);
        applyStimulus(4'b1010);
        waitIrq("prio_irq", 6);
        checkReg("prio_id1", ADDR_ISRC, 32'h1);
        pulseIack();
        busWrite(ADDR_ISRC, 32'h0);
        checkIrq("prio_idle_gap", 1'b0);
        tick();
        checkIrq("prio_rerise", 1'b1);
        checkReg("prio_id3", ADDR_ISRC, 32'h3);
        pulseIack();
        busWrite(ADDR_ISRC, 32'h0);
        checkReg("prio_ipend_empty", ADDR_IPEND, 32'h0);

        busWrite(ADDR_IMASK, 32'hE);
        applyStimulus(4'b0001);
        tick();
        tick();
        tick();
        checkIrq("mask_blocked", 1'b0);
        checkReg("mask_ipend", ADDR_IPEND, 32'h1);
        busWrite(ADDR_IMASK, 32'hF);
        waitIrq("mask_open_irq", 4);
        checkReg("mask_id0", ADDR_ISRC, 32'h0);
        pulseIack();
        busWrite(ADDR_ISRC, 32'h0);

        src = 4'b0100;
        tick();
        busWrite(ADDR_IPEND, 32'h4);
        checkReg("collision_set_wins", ADDR_IPEND, 32'h4);
        waitIrq("collision_irq", 4);
        checkReg("collision_id2", ADDR_ISRC, 32'h2);
        busWrite(ADDR_ICTL, 32'h0);
        checkIrq("gieclr_keeps_irq", 1'b1);
        checkReg("gieclr_ictl", ADDR_ICTL, 32'h0);
        busWrite(ADDR_IPEND, 32'h4);
        checkIrq("w1c_keeps_irq", 1'b1);
        checkReg("w1c_clears_bit", ADDR_IPEND, 32'h0);
        pulseIack();
        checkIrq("gieclr_iack_drop", 1'b0);
        busWrite(ADDR_ISRC, 32'h0);
        src = 4'b0;
        busWrite(ADDR_ICTL, 32'h1);
        tick();
        tick();
        checkIrq("gieclr_no_rereq", 1'b0);

        applyStimulus(4'b0001);
        waitIrq("rst_setup_irq", 6);
`else
        $display("[TB] level mode");
        busWrite(ADDR_ICTL, 32'h1);
        busWrite(ADDR_IMASK, 32'h2);
        checkReg("gie_rd", ADDR_ICTL, 32'h1);

        src = 4'b0010;
        tick();
        checkReg("level_tracks", ADDR_IPEND, 32'h2);
        waitIrq("level_irq", 4);
        checkReg("level_id1", ADDR_ISRC, 32'h1);
        busWrite(ADDR_IPEND, 32'h2);
        checkReg("level_w1c_noop", ADDR_IPEND, 32'h2);
        pulseIack();
        checkIrq("level_iack_drop", 1'b0);
        checkReg("level_isrc_serv", ADDR_ISRC, 32'h8000_0001);
        busWrite(ADDR_ISRC, 32'h0);
        checkIrq("level_idle_gap", 1'b0);
        tick();
        checkIrq("level_rereq", 1'b1);
        checkReg("level_rereq_id", ADDR_ISRC, 32'h1);
        pulseIack();
        src = 4'b0;
        busWrite(ADDR_ISRC, 32'h0);
        tick();
        tick();
        checkIrq("level_quiet", 1'b0);
        checkReg("level_ipend_drop", ADDR_IPEND, 32'h0);

        busWrite(ADDR_IMASK, 32'hF);
        src = 4'b1010;
        waitIrq("prio_irq", 4);
        checkReg("prio_id1", ADDR_ISRC, 32'h1);
        pulseIack();
        src = 4'b1000;
        busWrite(ADDR_ISRC, 32'h0);
        checkIrq("prio_idle_gap", 1'b0);
        tick();
        checkIrq("prio_rerise", 1'b1);
        checkReg("prio_id3", ADDR_ISRC, 32'h3);
        pulseIack();
        src = 4'b0;
        busWrite(ADDR_ISRC, 32'h0);

        busWrite(ADDR_IMASK, 32'hE);
        src = 4'b0001;
        tick();
        tick();
        tick();
        checkIrq("mask_blocked", 1'b0);
        checkReg("mask_ipend", ADDR_IPEND, 32'h1);
        busWrite(ADDR_IMASK, 32'hF);
        waitIrq("mask_open_irq", 4);
        checkReg("mask_id0", ADDR_ISRC, 32'h0);
        pulseIack();
        src = 4'b0;
        busWrite(ADDR_ISRC, 32'h0);

        src = 4'b0100;
        waitIrq("gie_setup_irq", 4);
        checkReg("gie_id2", ADDR_ISRC, 32'h2);
        busWrite(ADDR_ICTL, 32'h0);
        checkIrq("gieclr_keeps_irq", 1'b1);
        checkReg("gieclr_ictl", ADDR_ICTL, 32'h0);
        pulseIack();
        checkIrq("gieclr_iack_drop", 1'b0);
        src = 4'b0;
        busWrite(ADDR_ISRC, 32'h0);
        busWrite(ADDR_ICTL, 32'h1);
        tick();
        tick();
        checkIrq("gieclr_no_rereq", 1'b0);

        src = 4'b0001;
        waitIrq("rst_setup_irq", 4);
`endif

        initN = 1'b0;
        #1;
        checkIrq("rst_irq", 1'b0);
        checkReg("rst_ictl",  ADDR_ICTL,  32'h0);
        checkReg("rst_imask", ADDR_IMASK, 32'h0);
        checkReg("rst_ipend", ADDR_IPEND, 32'h0);
        checkReg("rst_isrc",  ADDR_ISRC,  32'h0);
        abus    = ADDR_NONE;
        tbData  = 32'hA5A5_5A5A;
        tbDrive = 1'b1;
        #1;
        checkOutput("rst_dbus_undriven", dbus, 32'hA5A5_5A5A);
        tbDrive = 1'b0;
        src = 4'b0;
        tick();
        initN = 1'b1;
        tick();
        tick();
        checkIrq("post_rst_irq", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
